// File: rtl/s_mem_sched_pkg.sv
// Shared types and constants for the RC4 S-memory phase scheduler.
// Requester indices double as the phase_done/req/gnt bit positions.
package s_mem_sched_pkg;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int NUM_REQ = 3;

    localparam int REQ_INIT = 0;
    localparam int REQ_KSA  = 1;
    localparam int REQ_PRGA = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_KSA   = 3'd2,
        ST_PRGA  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } sched_state_t;

    // Phase in which a given requester owns the memory port.
    function automatic sched_state_t req_phase(input int idx);
        case (idx)
            REQ_INIT: return ST_INIT;
            REQ_KSA:  return ST_KSA;
            default:  return ST_PRGA;
        endcase
    endfunction

endpackage

// File: rtl/s_mem_port_mux.sv
// Grant gating, memory port mux and one-cycle read-valid pipeline for the
// three S-memory requesters. active is one-hot of the phase owning the port.
module s_mem_port_mux #(
    parameter int ADDR_W = s_mem_sched_pkg::ADDR_W,
    parameter int DATA_W = s_mem_sched_pkg::DATA_W
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [s_mem_sched_pkg::NUM_REQ-1:0]        active,
    input  logic [s_mem_sched_pkg::NUM_REQ-1:0]        req,
    input  logic [s_mem_sched_pkg::NUM_REQ-1:0]        wren,
    input  logic [s_mem_sched_pkg::NUM_REQ*ADDR_W-1:0] addr,
    input  logic [s_mem_sched_pkg::NUM_REQ*DATA_W-1:0] wdata,
    output logic [s_mem_sched_pkg::NUM_REQ-1:0]        gnt,
    output logic [s_mem_sched_pkg::NUM_REQ-1:0]        rvalid,
    output logic [ADDR_W-1:0]                      mem_addr,
    output logic [DATA_W-1:0]                      mem_wdata,
    output logic                                   mem_wren
);
    import s_mem_sched_pkg::*;

    logic [NUM_REQ-1:0] rvalid_reg;
    logic [NUM_REQ-1:0] rvalid_next;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign gnt[gi]         = req[gi] & active[gi];
        assign rvalid_next[gi] = gnt[gi] & ~wren[gi];
    end

    // gnt is one-hot or zero, so a priority-free select is safe.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wren  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                mem_addr  = addr[i*ADDR_W +: ADDR_W];
                mem_wdata = wdata[i*DATA_W +: DATA_W];
                mem_wren  = wren[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid_reg <= '0;
        end else begin
            rvalid_reg <= rvalid_next;
        end
    end

    assign rvalid = rvalid_reg;

endmodule

// File: rtl/s_mem_sched.sv
// RC4 S-memory scheduler: sequences init -> KSA -> PRGA and arbitrates the port.
// Define SMEM_SCHED_TIMEOUT_EN to enable the per-phase watchdog and ERROR state.
module s_mem_sched #(
    parameter int ADDR_W         = s_mem_sched_pkg::ADDR_W,
    parameter int DATA_W         = s_mem_sched_pkg::DATA_W,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            req,
    input  logic [2:0]            wren,
    input  logic [3*ADDR_W-1:0]   addr,
    input  logic [3*DATA_W-1:0]   wdata,
    input  logic [2:0]            phase_done,
    output logic [2:0]            gnt,
    output logic [2:0]            rvalid,
    output logic [2:0]            phase_start,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_wren,
    output logic [2:0]            phase,
    output logic                  busy,
    output logic                  all_done,
    output logic                  seq_err,
    output logic                  timeout_err
);
    import s_mem_sched_pkg::*;

    sched_state_t       state_reg, state_next;
    logic [NUM_REQ-1:0] active;
    logic [NUM_REQ-1:0] phase_start_reg, phase_start_next;
    logic               seq_err_reg;
    logic               timeout_hit;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_phase
        assign active[gi]           = (state_reg == req_phase(gi));
        assign phase_start_next[gi] = (state_next != state_reg) && (state_next == req_phase(gi));
    end

`ifdef SMEM_SCHED_TIMEOUT_EN
    logic [15:0] cnt_reg;
    logic        timeout_err_reg;

    // A matching done on the last allowed cycle still wins over the timeout.
    assign timeout_hit = busy && (cnt_reg == 16'(TIMEOUT_CYCLES - 1)) && ~|(phase_done & active);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg         <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (state_next != state_reg) begin
                cnt_reg <= '0;
            end else if (busy) begin
                cnt_reg <= cnt_reg + 16'd1;
            end
            if (timeout_hit) begin
                timeout_err_reg <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_reg;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) state_next = ST_INIT;
            end
            ST_INIT: begin
                if (phase_done[REQ_INIT])  state_next = ST_KSA;
                else if (timeout_hit)      state_next = ST_ERROR;
            end
            ST_KSA: begin
                if (phase_done[REQ_KSA])   state_next = ST_PRGA;
                else if (timeout_hit)      state_next = ST_ERROR;
            end
            ST_PRGA: begin
                if (phase_done[REQ_PRGA])  state_next = ST_DONE;
                else if (timeout_hit)      state_next = ST_ERROR;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            phase_start_reg <= '0;
            seq_err_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            phase_start_reg <= phase_start_next;
            // Any done pulse from a requester that does not own the current phase.
            if (|(phase_done & ~active)) begin
                seq_err_reg <= 1'b1;
            end
        end
    end

    s_mem_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_port_mux (
        .clk       (clk),
        .reset     (reset),
        .active    (active),
        .req       (req),
        .wren      (wren),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wren  (mem_wren)
    );

    assign phase       = state_reg;
    assign phase_start = phase_start_reg;
    assign busy        = |active;
    assign all_done    = (state_reg == ST_DONE);
    assign seq_err     = seq_err_reg;

endmodule

// File: doc/s_mem_sched.md
Name: s_mem_sched

Overview:
- Phase scheduler and access arbiter for the single-port 256x8 S memory used by the RC4 flow.
- Sequences three requesters in fixed order: init loop (s[i]=i), KSA swap loop, PRGA/decrypt loop.
- Grants exactly one requester the memory port per phase, and routes the registered-read data-valid back to that requester.
- Replaces the ad-hoc first_done-driven mux; sits between the loop engines and s_memory.

Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width
- TIMEOUT_CYCLES, 4096, per-phase watchdog limit (used only with the optional feature)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a full init->KSA->PRGA run
- req  in  3  per-requester access request; bit 0=init, 1=KSA, 2=PRGA
- wren  in  3  per-requester write enable, qualified by req
- addr  in  3*ADDR_W  packed requester addresses; requester i uses [i*ADDR_W +: ADDR_W]
- wdata  in  3*DATA_W  packed requester write data
- phase_done  in  3  one-cycle done pulse from each requester
- gnt  out  3  grant; combinational
- rvalid  out  3  read-data-valid for each requester; registered
- phase_start  out  3  one-cycle start pulse to each requester
- mem_addr  out  ADDR_W  to s_memory address
- mem_wdata  out  DATA_W  to s_memory data
- mem_wren  out  1  to s_memory wren
- phase  out  3  current state encoding, for LEDs
- busy  out  1  high in INIT, KSA and PRGA
- all_done  out  1  high in DONE
- seq_err  out  1  sticky error flag
- timeout_err  out  1  sticky error flag

Behaviour:
- State encoding: IDLE=0, INIT=1, KSA=2, PRGA=3, DONE=4, ERROR=5.
- Reset (async, any time, including mid-phase):
  - state=IDLE.
  - All registered outputs 0: rvalid, phase_start, seq_err, timeout_err.
  - gnt=0, mem_wren=0, mem_addr=0, mem_wdata=0.
  - A read in flight is discarded; no rvalid is issued for it.
- State transitions:
  - IDLE + start -> INIT.
  - INIT + phase_done[0] -> KSA.
  - KSA + phase_done[1] -> PRGA.
  - PRGA + phase_done[2] -> DONE.
  - DONE + start -> INIT, which restarts the run.
  - start is ignored in INIT, KSA and PRGA.
- phase_start[i] is registered: high for exactly the first cycle in which state equals phase i.
- A phase_done bit that does not match the current phase is ignored, and sets seq_err (sticky until reset).
- Grant: gnt[i] = req[i] && (state == phase i). At most one grant bit is ever high.
  - Requests from non-active requesters get gnt=0; they stall and are not queued.
- Memory mux:
  - While gnt[i]: mem_addr=addr_i, mem_wdata=wdata_i, mem_wren=wren[i].
  - With no grant: mem_wren=0, mem_addr=0, mem_wdata=0.
- Read latency is 1 cycle:
  - rvalid[i] <= gnt[i] & ~wren[i].
  - Requesters sample the shared mem q in the cycle rvalid[i] is high.
  - rvalid is still delivered to the old requester if the phase advanced in the same cycle.
- Simultaneous req and phase_done in one cycle: the access is granted that cycle, and the phase advances at the next edge.
- The new phase's phase_start and its first possible grant occur in the same cycle.
- busy=1 in INIT, KSA and PRGA; all_done=1 in DONE.
- Without SMEM_SCHED_TIMEOUT_EN, ERROR is unreachable.

Optional Feature:
- Macro name: SMEM_SCHED_TIMEOUT_EN.
- Defined:
  - A 16-bit phase counter clears on phase entry and increments each cycle in INIT, KSA and PRGA.
  - If the counter reaches TIMEOUT_CYCLES-1 with no matching phase_done, the next state is ERROR and timeout_err sets (sticky).
  - In ERROR, all gnt=0 and busy=0. ERROR exits only via reset or start (start -> INIT).
- Undefined: no counter, no ERROR state, timeout_err tied to 0.

Decomposition:
- Package s_mem_sched_pkg holds:
  - the state enum (sched_state_t, 3 bits);
  - requester index constants REQ_INIT=0, REQ_KSA=1, REQ_PRGA=2;
  - the widths ADDR_W and DATA_W.
- One sub-module is natural: s_mem_port_mux. It contains the combinational grant logic, the address/data/wren mux and the rvalid pipeline register.
- The FSM and the optional watchdog stay in the top module.

Test Plan:
- Reset then start pulse:
  - phase goes 0->1; phase_start=3'b001 for one cycle; busy=1.
  - req=3'b001, wren=1, addr0=8'h05, wdata0=8'h05 -> gnt=3'b001, mem_wren=1, mem_addr=8'h05.
- In KSA, req=3'b011 with wren[1]=0 and addr1=8'h10:
  - gnt=3'b010 and mem_addr=8'h10;
  - next cycle rvalid=3'b010; requester 0 never granted.
- Full run: done pulses for phases 0, 1, 2 in order -> phase sequence 1,2,3,4; all_done=1; start in DONE -> phase=1 with phase_start[0] pulse.
- In INIT, assert phase_done[2] -> state stays INIT and seq_err=1. A later phase_done[0] -> KSA, with seq_err still 1.
- Assert reset mid-KSA during a granted read:
  - all outputs 0 immediately (async);
  - no rvalid after reset release;
  - phase=0.
- With SMEM_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16: enter INIT with no phase_done for 16 cycles -> phase=5, timeout_err=1, gnt=0 despite req=3'b001; start -> phase=1.
